// File: rtl/mult_reg_unit_n_if.sv
// Bus between the multiplier register unit and its controller/adder.
// Define BOOTH_EN to carry the Booth_Pair signal.
interface mult_reg_unit_n_if #(
   parameter int WIDTH = 8
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             Ld_B;
   logic             Clr_XA;
   logic             Ld_XA;
   logic             Shift_En;
   logic             x;
   logic [WIDTH-1:0] S_in;
   logic [WIDTH-1:0] D;
   logic             X;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             M;
   logic [CNT_W-1:0] Count;
   logic             Done;
`ifdef BOOTH_EN
   logic [1:0]       Booth_Pair;

   modport master (
      output Ld_B, Clr_XA, Ld_XA, Shift_En, x, S_in, D,
      input  X, A, B, M, Count, Done, Booth_Pair
   );
   modport slave (
      input  Ld_B, Clr_XA, Ld_XA, Shift_En, x, S_in, D,
      output X, A, B, M, Count, Done, Booth_Pair
   );
`else
   modport master (
      output Ld_B, Clr_XA, Ld_XA, Shift_En, x, S_in, D,
      input  X, A, B, M, Count, Done
   );
   modport slave (
      input  Ld_B, Clr_XA, Ld_XA, Shift_En, x, S_in, D,
      output X, A, B, M, Count, Done
   );
`endif
endinterface

// File: rtl/mult_reg_unit_n.sv
// {X,A,B} datapath register for the shift-add signed multiplier, with shift counter and Done.
// Define BOOTH_EN to add the Q_m1 register and the Booth_Pair output.
module mult_reg_unit_n #(
   parameter int WIDTH = 8
) (
   input logic              Clk,
   input logic              Reset,
   mult_reg_unit_n_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   logic             x_q, x_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_inc;
`ifdef BOOTH_EN
   logic             qm1_q, qm1_d;
`endif

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Only the highest-priority strobe acts; once Done is set the product is frozen.
   always_comb begin
      x_d    = x_q;
      a_d    = a_q;
      b_d    = b_q;
      cnt_d  = cnt_q;
      done_d = done_q;
`ifdef BOOTH_EN
      qm1_d  = qm1_q;
`endif
      if (bus.Ld_B) begin
         b_d    = bus.D;
         x_d    = 1'b0;
         a_d    = '0;
         cnt_d  = '0;
         done_d = 1'b0;
`ifdef BOOTH_EN
         qm1_d  = 1'b0;
`endif
      end else if (bus.Clr_XA) begin
         x_d    = 1'b0;
         a_d    = '0;
         cnt_d  = '0;
         done_d = 1'b0;
`ifdef BOOTH_EN
         qm1_d  = 1'b0;
`endif
      end else if (bus.Ld_XA) begin
         if (!done_q) begin
            x_d = bus.x;
            a_d = bus.S_in;
         end
      end else if (bus.Shift_En) begin
         if (!done_q) begin
            a_d   = {x_q, a_q[WIDTH-1:1]};
            b_d   = {a_q[0], b_q[WIDTH-1:1]};
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
               done_d = 1'b1;
            end
`ifdef BOOTH_EN
            qm1_d = b_q[0];
`endif
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         x_q    <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
`ifdef BOOTH_EN
         qm1_q  <= 1'b0;
`endif
      end else begin
         x_q    <= x_d;
         a_q    <= a_d;
         b_q    <= b_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
`ifdef BOOTH_EN
         qm1_q  <= qm1_d;
`endif
      end
   end

   assign bus.X     = x_q;
   assign bus.A     = a_q;
   assign bus.B     = b_q;
   assign bus.M     = b_q[0];
   assign bus.Count = cnt_q;
   assign bus.Done  = done_q;
`ifdef BOOTH_EN
   assign bus.Booth_Pair = {b_q[0], qm1_q};
`endif

endmodule

// File: tb/tb_mult_reg_unit_n.sv
// Bench for mult_reg_unit_n: directed scenarios plus random strobes against a reference model.
module tb_mult_reg_unit_n;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
   localparam int VW = 2 * W + CW + 3;

   logic Clk;
   logic Reset;
   logic clk_en;
   int   total;
   int   bad;

   mult_reg_unit_n_if #(.WIDTH(W)) bif ();

   mult_reg_unit_n #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bif)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 if (clk_en) Clk = ~Clk;

   // reference model state
   logic          m_x;
   logic [W-1:0]  m_a;
   logic [W-1:0]  m_b;
   int            m_cnt;
   logic          m_done;
   logic          m_q;

   function automatic logic [VW-1:0] dut_vec();
      return {bif.X, bif.A, bif.B, bif.Count, bif.Done, bif.M};
   endfunction

   function automatic logic [VW-1:0] model_vec();
      return {m_x, m_a, m_b, CW'(m_cnt), m_done, m_b[0]};
   endfunction

   task automatic model_reset();
      m_x = 1'b0; m_a = '0; m_b = '0; m_cnt = 0; m_done = 1'b0; m_q = 1'b0;
   endtask

   // The whole {X,A,B} word is shifted as one signed quantity.
   task automatic model_edge();
      logic [2*W:0] r;
      if (bif.Ld_B) begin
         m_b = bif.D; m_x = 1'b0; m_a = '0; m_cnt = 0; m_done = 1'b0; m_q = 1'b0;
      end else if (bif.Clr_XA) begin
         m_x = 1'b0; m_a = '0; m_cnt = 0; m_done = 1'b0; m_q = 1'b0;
      end else if (bif.Ld_XA) begin
         if (!m_done) begin
            m_x = bif.x;
            m_a = bif.S_in;
         end
      end else if (bif.Shift_En) begin
         if (!m_done) begin
            m_q = m_b[0];
            r = $signed({m_x, m_a, m_b}) >>> 1;
            {m_x, m_a, m_b} = r;
            m_cnt = m_cnt + 1;
            m_done = (m_cnt == W);
         end
      end
   endtask

   // driver: apply strobes for one edge, update the model, release strobes
   task automatic drive(input logic ld_b, input logic clr, input logic ld_xa, input logic sh,
                        input logic xin, input logic [W-1:0] s, input logic [W-1:0] d);
      bif.Ld_B = ld_b; bif.Clr_XA = clr; bif.Ld_XA = ld_xa; bif.Shift_En = sh;
      bif.x = xin; bif.S_in = s; bif.D = d;
      @(posedge Clk);
      model_edge();
      #1;
      bif.Ld_B = 1'b0; bif.Clr_XA = 1'b0; bif.Ld_XA = 1'b0; bif.Shift_En = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      #1;
      model_reset();
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++; $display("FAIL reset_no_clock: got %h want %h", dut_vec(), model_vec());
      end
      Reset = 1'b0;
      #2;
      clk_en = 1'b1;
   endtask

   task automatic test_single_shift();
      logic [VW-1:0] lit;
      drive(1, 0, 0, 0, 0, 8'h00, 8'h07);
      drive(0, 0, 1, 0, 1, 8'hC5, 8'h00);
      drive(0, 0, 0, 1, 0, 8'h00, 8'h00);
      lit = {1'b1, 8'hE2, 8'h83, CW'(1), 1'b0, 1'b1};
      total++;
      if (dut_vec() !== lit) begin
         bad++; $display("FAIL single_shift: got %h want %h", dut_vec(), lit);
      end
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++; $display("FAIL single_shift_model: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_saturate();
      drive(1, 0, 0, 0, 0, 8'h00, 8'h05);
      for (int i = 0; i < W; i++) begin
         drive(0, 0, 0, 1, 0, 8'h00, 8'h00);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL saturate_shift%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      total++;
      if ({bif.Count, bif.Done} !== {CW'(W), 1'b1}) begin
         bad++; $display("FAIL saturate_done: got count=%0d done=%b want count=%0d done=1",
                         bif.Count, bif.Done, W);
      end
      drive(0, 0, 1, 1, 1, 8'hFF, 8'h00);
      total++;
      if ({bif.A, bif.B, bif.Count, bif.Done} !== {8'h00, 8'h00, CW'(W), 1'b1}) begin
         bad++; $display("FAIL saturate_hold: got A=%h B=%h count=%0d done=%b want A=00 B=00 count=%0d done=1",
                         bif.A, bif.B, bif.Count, bif.Done, W);
      end
   endtask

   // Bench-side adder: add the multiplicand when M=1, subtract it on the sign bit's turn.
   task automatic test_multiply(input logic [W-1:0] mplier, input logic [W-1:0] mcand);
      logic [W:0]     s9;
      logic [W:0]     mc9;
      logic [2*W-1:0] exp_p;
      int             p;
      mc9 = {mcand[W-1], mcand};
      drive(1, 0, 0, 0, 0, 8'h00, mplier);
      for (int i = 0; i < W; i++) begin
         if (m_b[0]) begin
            s9 = (i == W - 1) ? ({m_x, m_a} - mc9) : ({m_x, m_a} + mc9);
            drive(0, 0, 1, 0, s9[W], s9[W-1:0], 8'h00);
         end
         drive(0, 0, 0, 1, 0, 8'h00, 8'h00);
      end
      p = int'($signed(mplier)) * int'($signed(mcand));
      exp_p = p[2*W-1:0];
      total++;
      if ({bif.A, bif.B, bif.Done, bif.X} !== {exp_p, 1'b1, exp_p[2*W-1]}) begin
         bad++; $display("FAIL multiply %h*%h: got AB=%h done=%b X=%b want AB=%h done=1 X=%b",
                         mplier, mcand, {bif.A, bif.B}, bif.Done, bif.X, exp_p, exp_p[2*W-1]);
      end
   endtask

   task automatic test_priority();
      drive(0, 0, 1, 0, 1, 8'h99, 8'h00);
      drive(1, 0, 0, 1, 0, 8'h00, 8'h3C);
      total++;
      if ({bif.B, bif.A, bif.Count} !== {8'h3C, 8'h00, CW'(0)}) begin
         bad++; $display("FAIL prio_ldb_shift: got B=%h A=%h count=%0d want B=3c A=00 count=0",
                         bif.B, bif.A, bif.Count);
      end
      drive(0, 0, 1, 0, 1, 8'h5A, 8'h00);
      drive(0, 1, 1, 0, 1, 8'h77, 8'h00);
      total++;
      if ({bif.X, bif.A, bif.B} !== {1'b0, 8'h00, 8'h3C}) begin
         bad++; $display("FAIL prio_clr_ldxa: got X=%b A=%h B=%h want X=0 A=00 B=3c",
                         bif.X, bif.A, bif.B);
      end
   endtask

   task automatic test_mid_reset();
      drive(1, 0, 0, 0, 0, 8'h00, 8'($urandom_range(1, 255)));
      drive(0, 0, 1, 0, 1, 8'($urandom_range(0, 255)), 8'h00);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 8'h00, 8'h00);
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++; $display("FAIL mid_reset: got %h want %h", dut_vec(), model_vec());
      end
      #1;
      Reset = 1'b0;
      drive(1, 0, 0, 0, 0, 8'h00, 8'hAA);
      total++;
      if ({bif.B, bif.Count} !== {8'hAA, CW'(0)}) begin
         bad++; $display("FAIL post_reset_load: got B=%h count=%0d want B=aa count=0", bif.B, bif.Count);
      end
`ifdef BOOTH_EN
      drive(0, 0, 0, 1, 0, 8'h00, 8'h00);
      total++;
      if (bif.Booth_Pair !== 2'b10) begin
         bad++; $display("FAIL booth_pair: got %b want 10", bif.Booth_Pair);
      end
`endif
   endtask

   task automatic test_random();
      logic ld_b, clr, ld_xa, sh;
      for (int i = 0; i < 400; i++) begin
         ld_b  = ($urandom_range(0, 15) == 0);
         clr   = ($urandom_range(0, 15) == 0);
         ld_xa = ($urandom_range(0, 3) == 0);
         sh    = ($urandom_range(0, 3) != 0);
         drive(ld_b, clr, ld_xa, sh, 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL random_step%0d: got %h want %h", i, dut_vec(), model_vec());
         end
`ifdef BOOTH_EN
         total++;
         if (bif.Booth_Pair !== {m_b[0], m_q}) begin
            bad++; $display("FAIL random_booth%0d: got %b want %b", i, bif.Booth_Pair, {m_b[0], m_q});
         end
`endif
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clk_en = 1'b0;
      Reset = 1'b0;
      bif.Ld_B = 1'b0; bif.Clr_XA = 1'b0; bif.Ld_XA = 1'b0; bif.Shift_En = 1'b0;
      bif.x = 1'b0; bif.S_in = '0; bif.D = '0;
      model_reset();
      #3;
      test_reset();
      test_single_shift();
      test_saturate();
      test_multiply(8'h05, 8'hFD);
      for (int k = 0; k < 12; k++) begin
         test_multiply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      test_multiply(8'h80, 8'h80);
      test_multiply(8'hFF, 8'h7F);
      test_priority();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
